// File: rtl/canny_pkg.sv
// Project-wide constants and shared types for the canny_edge pixel path.
package canny_pkg;

    localparam int IMG_W = 512;
    localparam int IMG_H = 512;
    localparam int PAD   = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    // Line width seen by the edge pipeline once the zero border is added.
    function automatic int padded_w(input int img_w, input int pad);
        return img_w + 2 * pad;
    endfunction

    localparam int PAD_W = padded_w(IMG_W, PAD);

endpackage

// File: rtl/raster_counter.sv
// Column/row position counter over a W x H raster, with end-of-line and end-of-frame flags.
module raster_counter #(
    parameter int W  = 6,
    parameter int H  = 5,
    parameter int CW = (W > 1) ? $clog2(W) : 1,
    parameter int RW = (H > 1) ? $clog2(H) : 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clear,
    input  logic          i_advance,
    output logic [CW-1:0] o_col,
    output logic [RW-1:0] o_row,
    output logic          o_last_col,
    output logic          o_last_pos
);

    localparam logic [CW-1:0] LP_COL_LAST = CW'(W - 1);
    localparam logic [RW-1:0] LP_ROW_LAST = RW'(H - 1);

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_advance) begin
            if (r_col == LP_COL_LAST) begin
                r_col <= '0;
                r_row <= (r_row == LP_ROW_LAST) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign o_col      = r_col;
    assign o_row      = r_row;
    assign o_last_col = (r_col == LP_COL_LAST);
    assign o_last_pos = (r_col == LP_COL_LAST) && (r_row == LP_ROW_LAST);

endmodule

// File: rtl/canny_pixel_source.sv
// Streams one zero-padded greyscale frame from a synchronous-read memory, one pixel per clock,
// then emits trailing zeros so the edge pipeline drains, and pulses done.
module canny_pixel_source #(
    parameter int IMG_W        = canny_pkg::IMG_W,
    parameter int IMG_H        = canny_pkg::IMG_H,
    parameter int PAD          = canny_pkg::PAD,
    parameter int FLUSH_CYCLES = 4096,
    parameter int ADDR_W       = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rd_data,
    output logic [7:0]        PixelData,
    output logic              pix_valid,
    output logic              sof,
    output logic              eol,
    output logic              busy,
    output logic              done
);
    import canny_pkg::*;

    localparam int W  = padded_w(IMG_W, PAD);
    localparam int H  = IMG_H + 2 * PAD;
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam int RW = (H > 1) ? $clog2(H) : 1;
    localparam int FW = $clog2(FLUSH_CYCLES + 1);

    localparam logic [CW-1:0]     LP_COL_LO     = CW'(PAD);
    localparam logic [CW-1:0]     LP_COL_HI     = CW'(PAD + IMG_W);
    localparam logic [RW-1:0]     LP_ROW_LO     = RW'(PAD);
    localparam logic [RW-1:0]     LP_ROW_HI     = RW'(PAD + IMG_H);
    localparam logic [ADDR_W-1:0] LP_IMG_W_A    = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] LP_PAD_A      = ADDR_W'(PAD);
    localparam logic [FW-1:0]     LP_FLUSH_LAST = FW'(FLUSH_CYCLES - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic              w_accept;
    logic              w_streaming;
    logic              w_flush_last;
    logic [CW-1:0]     w_col;
    logic [RW-1:0]     w_row;
    logic              w_last_col;
    logic              w_last_pos;
    logic              w_pad;
    logic [ADDR_W-1:0] w_addr;
    logic [FW-1:0]     r_flush_cnt;

    logic              r_s1_valid;
    logic              r_s1_pad;
    logic              r_s1_sof;
    logic              r_s1_eol;
    logic [7:0]        r_pix_data;
    logic              r_pix_valid;
    logic              r_sof;
    logic              r_eol;

    raster_counter #(
        .W  (W),
        .H  (H),
        .CW (CW),
        .RW (RW)
    ) u_raster (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_clear    (w_accept),
        .i_advance  (w_streaming),
        .o_col      (w_col),
        .o_row      (w_row),
        .o_last_col (w_last_col),
        .o_last_pos (w_last_pos)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start)        w_next_state = STREAM;
            STREAM:  if (w_last_pos)   w_next_state = FLUSH;
            FLUSH:   if (w_flush_last) w_next_state = IDLE;
            default:                   w_next_state = IDLE;
        endcase
    end

    // The flush window is counted on the output side: the two in-flight frame pixels
    // still show pix_valid=1 after entering FLUSH and are not counted.
    always_comb begin
        w_accept     = (r_state == IDLE) && start;
        w_streaming  = (r_state == STREAM);
        w_flush_last = (r_state == FLUSH) && !r_pix_valid && (r_flush_cnt == LP_FLUSH_LAST);
        busy         = (r_state != IDLE);
        done         = w_flush_last;
    end

    always_ff @(posedge clk) begin
        if (rst || (r_state != FLUSH)) begin
            r_flush_cnt <= '0;
        end else if (!r_pix_valid) begin
            r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    always_comb begin
        w_pad = (w_col < LP_COL_LO) || (w_col >= LP_COL_HI) ||
                (w_row < LP_ROW_LO) || (w_row >= LP_ROW_HI);
        w_addr = (ADDR_W'(w_row) - LP_PAD_A) * LP_IMG_W_A + (ADDR_W'(w_col) - LP_PAD_A);
        mem_rd_en = w_streaming && !w_pad;
        mem_addr  = mem_rd_en ? w_addr : '0;
    end

    // Stage 1 shadows the memory read; stage 2 is the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_pad    <= 1'b0;
            r_s1_sof    <= 1'b0;
            r_s1_eol    <= 1'b0;
            r_pix_data  <= 8'd0;
            r_pix_valid <= 1'b0;
            r_sof       <= 1'b0;
            r_eol       <= 1'b0;
        end else begin
            r_s1_valid  <= w_streaming;
            r_s1_pad    <= w_pad;
            r_s1_sof    <= w_streaming && (w_col == '0) && (w_row == '0);
            r_s1_eol    <= w_streaming && w_last_col;
            r_pix_data  <= (r_s1_valid && !r_s1_pad) ? mem_rd_data : 8'd0;
            r_pix_valid <= r_s1_valid;
            r_sof       <= r_s1_sof;
            r_eol       <= r_s1_eol;
        end
    end

    assign PixelData = r_pix_data;
    assign pix_valid = r_pix_valid;
    assign sof       = r_sof;
    assign eol       = r_eol;

endmodule

// File: tb/tb_canny_pixel_source.sv
// Self-checking bench for canny_pixel_source on a 4x3 image with a 1-pixel border.
module tb_canny_pixel_source;
    import canny_pkg::*;

    localparam int IMG_W        = 4;
    localparam int IMG_H        = 3;
    localparam int PAD          = 1;
    localparam int FLUSH_CYCLES = 5;
    localparam int ADDR_W       = 4;
    localparam int W            = IMG_W + 2 * PAD;
    localparam int H            = IMG_H + 2 * PAD;
    localparam int NPIX         = W * H;
    localparam int NREADS       = IMG_W * IMG_H;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rd_data = 8'd0;
    logic [7:0]        PixelData;
    logic              pix_valid;
    logic              sof;
    logic              eol;
    logic              busy;
    logic              done;

    logic [7:0]        mem [16];
    logic [9:0]        exp_q[$];
    logic [ADDR_W-1:0] exp_addr = '0;
    logic              prev_done = 1'b0;
    int                n_checks = 0;
    int                n_errors = 0;
    int                cyc = 0;
    int                start_cyc = 0;
    int                last_valid_cyc = 0;
    int                n_valid = 0;
    int                n_reads = 0;
    int                n_done = 0;

    canny_pixel_source #(
        .IMG_W        (IMG_W),
        .IMG_H        (IMG_H),
        .PAD          (PAD),
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .ADDR_W       (ADDR_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .PixelData   (PixelData),
        .pix_valid   (pix_valid),
        .sof         (sof),
        .eol         (eol),
        .busy        (busy),
        .done        (done)
    );

    // ---------------- clock / reset / memory model ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        for (int a = 0; a < 16; a++) mem[a] = 8'(a + 1);
    end

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin : monitor
        logic [9:0] e;
        if (rst) begin
            prev_done = 1'b0;
        end else begin
            if (mem_rd_en) begin
                check("rd_addr", 32'(mem_addr), 32'(exp_addr));
                exp_addr = exp_addr + 1'b1;
                n_reads++;
            end
            if (pix_valid) begin
                check("q_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("pixel", 32'({sof, eol, PixelData}), 32'(e));
                end
                if (sof) check("sof_latency", 32'(cyc - start_cyc), 32'd3);
                n_valid++;
                last_valid_cyc = cyc;
            end else begin
                check("idle_out_zero", 32'({sof, eol, PixelData}), 32'd0);
            end
            if (done) begin
                n_done++;
                check("done_gap", 32'(cyc - last_valid_cyc), 32'(FLUSH_CYCLES));
            end
            if (prev_done) check("busy_after_done", 32'(busy), 32'd0);
            prev_done = done;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_frame();
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                logic       is_pad;
                logic [7:0] px;
                is_pad = (c < PAD) || (c >= PAD + IMG_W) || (r < PAD) || (r >= PAD + IMG_H);
                px = is_pad ? 8'd0 : 8'((r - PAD) * IMG_W + (c - PAD) + 1);
                exp_q.push_back({(r == 0 && c == 0), (c == W - 1), px});
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_frame();
        check("idle_before_start", 32'(busy), 32'd0);
        push_frame();
        exp_addr  = '0;
        n_valid   = 0;
        n_reads   = 0;
        n_done    = 0;
        start_cyc = cyc;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic wait_valid(input int n);
        int i;
        for (i = 0; i < 200; i++) begin
            if (n_valid >= n) break;
            tick();
        end
        if (i == 200) check("valid_timeout", 32'(n_valid), 32'(n));
    endtask

    // Returns at the start of the cycle in which done is high.
    task automatic wait_done();
        int i;
        for (i = 0; i < 200; i++) begin
            tick();
            if (done) break;
        end
        if (i == 200) check("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic end_checks(input string tag);
        check({tag, "_valid_count"}, 32'(n_valid), 32'(NPIX));
        check({tag, "_read_count"}, 32'(n_reads), 32'(NREADS));
        check({tag, "_done_count"}, 32'(n_done), 32'd1);
        check({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_outputs"},
              32'({PixelData, pix_valid, sof, eol, busy, done, mem_rd_en, mem_addr}), 32'd0);
        check({tag, "_state"}, 32'(dut.r_state), 32'(IDLE));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Plain frame: latency, padded content, eol spacing, flush length, done/busy.
        begin_frame();
        wait_done();
        tick();
        end_checks("frame1");

        // start while busy and in the done cycle must be ignored.
        begin_frame();
        wait_valid(10);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        end_checks("ignored_start");
        check("idle_after_ignored", 32'(busy), 32'd0);

        // Mid-frame reset aborts with no done, then a fresh frame replays from sof.
        begin_frame();
        wait_valid(15);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_zero("abort");
        exp_q.delete();
        repeat (20) tick();
        check("abort_no_done", 32'(n_done), 32'd0);
        check("abort_valid_count", 32'(n_valid), 32'd15);
        begin_frame();
        wait_done();
        tick();
        end_checks("replay");

        // Back-to-back frames: second start one cycle after done.
        begin_frame();
        wait_done();
        tick();
        end_checks("b2b_a");
        begin_frame();
        wait_done();
        tick();
        end_checks("b2b_b");

        repeat (5) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
